// File: rtl/clock_time_counter.sv
// Time-of-day counter: divides clk to a 1 Hz tick, keeps h:m:s and supports a
// button-driven set mode that edits one field at a time.
module clock_time_counter #(
   parameter int CLK_DIV = 100_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mode_btn,
   input  logic        inc_btn,
   input  logic        dec_btn,
   input  logic        pause,
   output logic [16:0] seconds,
   output logic        sec_tick,
   output logic [1:0]  set_field,
   output logic        running
);

   // Encodings double as the set_field value.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } state_t;

   localparam logic [31:0] DIV_MAX = 32'(CLK_DIV - 1);

   state_t      state;
   logic [4:0]  h;
   logic [5:0]  m;
   logic [5:0]  s;
   logic [31:0] div_cnt;
   logic        edit;

   function automatic logic [5:0] step_mod(input logic [5:0] v,
                                           input logic [5:0] vmax,
                                           input logic       up);
      if (up)
         return (v == vmax) ? 6'd0 : v + 6'd1;
      else
         return (v == 6'd0) ? vmax : v - 6'd1;
   endfunction

   assign seconds   = 17'(h) * 17'd3600 + 17'(m) * 17'd60 + 17'(s);
   assign set_field = state;
   assign running   = (state == RUN) && !pause;
   assign edit      = inc_btn ^ dec_btn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         h        <= '0;
         m        <= '0;
         s        <= '0;
         div_cnt  <= '0;
         sec_tick <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         case (state)
            RUN: begin
               // The tick increment still applies when mode_btn leaves RUN on the same edge.
               if (!pause) begin
                  if (div_cnt == DIV_MAX) begin
                     div_cnt  <= '0;
                     sec_tick <= 1'b1;
                     if (s == 6'd59) begin
                        s <= '0;
                        if (m == 6'd59) begin
                           m <= '0;
                           h <= (h == 5'd23) ? 5'd0 : h + 5'd1;
                        end else begin
                           m <= m + 6'd1;
                        end
                     end else begin
                        s <= s + 6'd1;
                     end
                  end else begin
                     div_cnt <= div_cnt + 32'd1;
                  end
               end
               if (mode_btn)
                  state <= SET_H;
            end
            SET_H: begin
               div_cnt <= '0;
               if (mode_btn)
                  state <= SET_M;
               else if (edit)
                  h <= 5'(step_mod({1'b0, h}, 6'd23, inc_btn));
            end
            SET_M: begin
               div_cnt <= '0;
               if (mode_btn)
                  state <= SET_S;
               else if (edit)
                  m <= step_mod(m, 6'd59, inc_btn);
            end
            SET_S: begin
               div_cnt <= '0;
               if (mode_btn)
                  state <= RUN;
               else if (edit)
                  s <= step_mod(s, 6'd59, inc_btn);
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
